// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage with credit-limited imem requests, in-order responses and an instruction FIFO
module instr_fetch #(
  parameter int DWIDTH = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [DWIDTH-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DWIDTH-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DWIDTH-1:0] instr,
  output logic [DWIDTH-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [DWIDTH-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [DWIDTH-1:0] pc;
  logic [CW-1:0] outst, outst_nxt, fcnt;
  logic [DWIDTH-1:0] pend [DEPTH];
  logic [DWIDTH-1:0] fdata [DEPTH];
  logic [DWIDTH-1:0] fpc [DEPTH];
  logic accept, push, pop;
  assign imem_req_valid = state == RUN && !redirect_valid && (int'(outst) + int'(fcnt) < DEPTH);
  assign imem_req_addr = pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign push = state == RUN && imem_rsp_valid && !redirect_valid;
  assign instr_valid = fcnt != '0;
  assign pop = instr_valid && instr_ready && !redirect_valid;
  assign outst_nxt = outst + CW'(accept) - CW'(imem_rsp_valid);
  assign instr = fdata[0];
  assign instr_pc = fpc[0];
  // next state: leave IDLE at once, drain stale responses after a redirect
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = RUN;
    else if (state == RUN && redirect_valid && outst_nxt != '0) state_nxt = DRAIN;
    else if (state == DRAIN && outst_nxt == '0) state_nxt = RUN;
  end
  // state, pc and the credit counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      pc <= RESET_PC;
      outst <= '0;
      fcnt <= '0;
    end else begin
      state <= state_nxt;
      pc <= (redirect_valid && state != IDLE) ? redirect_pc : accept ? pc + DWIDTH'(4) : pc;
      outst <= outst_nxt;
      fcnt <= redirect_valid ? '0 : fcnt + CW'(push) - CW'(pop);
    end
  end
  // pending-PC queue: head is the PC of the oldest outstanding request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (imem_rsp_valid) pend[i] <= pend[(i + 1) % DEPTH];
        if (accept && i == int'(outst) - int'(imem_rsp_valid)) pend[i] <= pc;
      end
    end
  end
  // shifting FIFO; entry 0 is the head and is left in place when the last word leaves
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fdata[i] <= '0;
        fpc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && i + 1 < int'(fcnt)) begin
          fdata[i] <= fdata[(i + 1) % DEPTH];
          fpc[i] <= fpc[(i + 1) % DEPTH];
        end
        if (push && i == int'(fcnt) - int'(pop)) begin
          fdata[i] <= imem_rsp_data;
          fpc[i] <= pend[0];
        end
      end
    end
  end
endmodule
